// File: rtl/mu_transition_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : mu_transition_ramp
//  Description : Slew limiter for the six MU*dt oscillator gains and the
//                Ca2+ threshold. On a cognitive-state switch each channel
//                walks toward its target by at most one bounded step per
//                dwell interval, so the Hopf oscillators never see a gain
//                step. A single-cycle pulse marks ramp completion.
//                Optional feature macro: MU_RAMP_HOLD_EN (adds hold_req,
//                which freezes an active ramp and blocks new ramps).
//  Revision    : 1.0  initial release
// ============================================================================
module mu_transition_ramp #(
    parameter int WIDTH       = 18,
    parameter int FRAC        = 14,
    parameter int MU_STEP     = 1,
    parameter int CA_STEP     = 512,
    parameter int DWELL_TICKS = 16,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
`ifdef MU_RAMP_HOLD_EN
    input  logic                    hold_req,
`endif
    input  logic signed [WIDTH-1:0] tgt_mu_theta,
    input  logic signed [WIDTH-1:0] tgt_mu_l6,
    input  logic signed [WIDTH-1:0] tgt_mu_l5b,
    input  logic signed [WIDTH-1:0] tgt_mu_l5a,
    input  logic signed [WIDTH-1:0] tgt_mu_l4,
    input  logic signed [WIDTH-1:0] tgt_mu_l23,
    input  logic signed [WIDTH-1:0] tgt_ca_threshold,
    output logic signed [WIDTH-1:0] mu_theta,
    output logic signed [WIDTH-1:0] mu_l6,
    output logic signed [WIDTH-1:0] mu_l5b,
    output logic signed [WIDTH-1:0] mu_l5a,
    output logic signed [WIDTH-1:0] mu_l4,
    output logic signed [WIDTH-1:0] mu_l23,
    output logic signed [WIDTH-1:0] ca_threshold,
    output logic                    ramping,
    output logic                    settled_pulse
);

    // Channel index 0..5 are the MU gains, index 6 is the Ca2+ threshold.
    localparam int                      c_NCH      = 7;
    localparam int                      c_CA_IDX   = 6;
    localparam logic signed [WIDTH-1:0] c_MU_RST   = WIDTH'(4);
    // 0.5 in the Q-format of the threshold
    localparam logic signed [WIDTH-1:0] c_CA_RST   = WIDTH'(1 << (FRAC - 1));
    localparam logic signed [WIDTH:0]   c_MU_STEP  = (WIDTH+1)'(MU_STEP);
    localparam logic signed [WIDTH:0]   c_CA_STEP  = (WIDTH+1)'(CA_STEP);
    localparam logic [CNT_W-1:0]        c_CNT_LOAD = CNT_W'(DWELL_TICKS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic signed [WIDTH-1:0] r_cur     [c_NCH];
    logic signed [WIDTH-1:0] w_cur_nxt [c_NCH];
    logic signed [WIDTH-1:0] w_tgt     [c_NCH];
    logic signed [WIDTH-1:0] w_step    [c_NCH];
    logic                    r_pulse;
    logic                    w_pulse_nxt;
    logic                    w_eq_now;
    logic                    w_eq_step;
    logic                    w_hold;

`ifdef MU_RAMP_HOLD_EN
    assign w_hold = hold_req;
`else
    assign w_hold = 1'b0;
`endif

    assign w_tgt[0] = tgt_mu_theta;
    assign w_tgt[1] = tgt_mu_l6;
    assign w_tgt[2] = tgt_mu_l5b;
    assign w_tgt[3] = tgt_mu_l5a;
    assign w_tgt[4] = tgt_mu_l4;
    assign w_tgt[5] = tgt_mu_l23;
    assign w_tgt[6] = tgt_ca_threshold;

    assign mu_theta      = r_cur[0];
    assign mu_l6         = r_cur[1];
    assign mu_l5b        = r_cur[2];
    assign mu_l5a        = r_cur[3];
    assign mu_l4         = r_cur[4];
    assign mu_l23        = r_cur[5];
    assign ca_threshold  = r_cur[6];
    assign ramping       = (r_state == S_RAMP);
    assign settled_pulse = r_pulse;

    // One bounded move toward the target; the difference is taken one bit
    // wider so opposite-sign extremes cannot wrap.
    function automatic logic signed [WIDTH-1:0] f_step(
        input logic signed [WIDTH-1:0] cur,
        input logic signed [WIDTH-1:0] tgt,
        input logic signed [WIDTH:0]   step
    );
        logic signed [WIDTH:0] d;
        logic signed [WIDTH:0] s;
        d = {tgt[WIDTH-1], tgt} - {cur[WIDTH-1], cur};
        s = {cur[WIDTH-1], cur};
        if ((d <= step) && (d >= -step)) begin
            s = {tgt[WIDTH-1], tgt};
        end else if (d > 0) begin
            s = s + step;
        end else begin
            s = s - step;
        end
        return s[WIDTH-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < c_NCH; gi++) begin : g_ch
            localparam logic signed [WIDTH:0] c_STEP =
                (gi == c_CA_IDX) ? c_CA_STEP : c_MU_STEP;
            assign w_step[gi] = f_step(r_cur[gi], w_tgt[gi], c_STEP);
        end
    endgenerate

    // Settle detection: now (IDLE entry) and after a candidate step (ramp end)
    always_comb begin
        w_eq_now  = 1'b1;
        w_eq_step = 1'b1;
        for (int i = 0; i < c_NCH; i++) begin
            if (r_cur[i] != w_tgt[i]) w_eq_now  = 1'b0;
            if (w_step[i] != w_tgt[i]) w_eq_step = 1'b0;
        end
    end

    // Next-state, dwell counter, channel values and completion pulse
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        for (int i = 0; i < c_NCH; i++) begin
            w_cur_nxt[i] = r_cur[i];
        end
        if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_eq_now && !w_hold) begin
                        w_state_nxt = S_RAMP;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
                S_RAMP: begin
                    if (!w_hold) begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end else begin
                            for (int i = 0; i < c_NCH; i++) begin
                                w_cur_nxt[i] = w_step[i];
                            end
                            w_cnt_nxt = c_CNT_LOAD;
                            if (w_eq_step) begin
                                w_pulse_nxt = 1'b1;
                                w_state_nxt = S_IDLE;
                                w_cnt_nxt   = '0;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter, channel and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            for (int i = 0; i < c_NCH; i++) begin
                r_cur[i] <= (i == c_CA_IDX) ? c_CA_RST : c_MU_RST;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            for (int i = 0; i < c_NCH; i++) begin
                r_cur[i] <= w_cur_nxt[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mu_transition_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mu_transition_ramp
//  Description : Self-checking bench for mu_transition_ramp: a vector table
//                for the main anesthesia ramp plus directed sequences for
//                retarget, clk_en stall, async reset, a coarse-step
//                instance and (with MU_RAMP_HOLD_EN) the hold request.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mu_transition_ramp;

    localparam int W = 18;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b0;
    logic en1    = 1'b0;
    logic hold   = 1'b0;

    logic signed [W-1:0] tgt  [7];
    logic signed [W-1:0] q    [7];
    logic                ramp;
    logic                pulse;
    logic signed [W-1:0] tgt1 [7];
    logic signed [W-1:0] q1   [7];
    logic                ramp1;
    logic                pulse1;

    int tests = 0;
    int fails = 0;

    string cn [7] = '{"mu_theta", "mu_l6", "mu_l5b", "mu_l5a", "mu_l4",
                      "mu_l23", "ca_threshold"};

    always #5 clk = ~clk;

    mu_transition_ramp u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
`ifdef MU_RAMP_HOLD_EN
        .hold_req         (hold),
`endif
        .tgt_mu_theta     (tgt[0]),
        .tgt_mu_l6        (tgt[1]),
        .tgt_mu_l5b       (tgt[2]),
        .tgt_mu_l5a       (tgt[3]),
        .tgt_mu_l4        (tgt[4]),
        .tgt_mu_l23       (tgt[5]),
        .tgt_ca_threshold (tgt[6]),
        .mu_theta         (q[0]),
        .mu_l6            (q[1]),
        .mu_l5b           (q[2]),
        .mu_l5a           (q[3]),
        .mu_l4            (q[4]),
        .mu_l23           (q[5]),
        .ca_threshold     (q[6]),
        .ramping          (ramp),
        .settled_pulse    (pulse)
    );

    mu_transition_ramp #(
        .CA_STEP     (1000),
        .DWELL_TICKS (1)
    ) u_coarse (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (en1),
`ifdef MU_RAMP_HOLD_EN
        .hold_req         (1'b0),
`endif
        .tgt_mu_theta     (tgt1[0]),
        .tgt_mu_l6        (tgt1[1]),
        .tgt_mu_l5b       (tgt1[2]),
        .tgt_mu_l5a       (tgt1[3]),
        .tgt_mu_l4        (tgt1[4]),
        .tgt_mu_l23       (tgt1[5]),
        .tgt_ca_threshold (tgt1[6]),
        .mu_theta         (q1[0]),
        .mu_l6            (q1[1]),
        .mu_l5b           (q1[2]),
        .mu_l5a           (q1[3]),
        .mu_l4            (q1[4]),
        .mu_l23           (q1[5]),
        .ca_threshold     (q1[6]),
        .ramping          (ramp1),
        .settled_pulse    (pulse1)
    );

    typedef struct {
        int n;        // clk_en ticks applied before sampling
        int t [7];    // targets
        int e [7];    // expected outputs
        int ramp;
        int pulse;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; each cycle the posedge consumes clk_en, returns
    // at the following negedge with outputs settled.
    task automatic cyc(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            clk_en = en;
            @(negedge clk);
        end
        clk_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        clk_en = 1'b0;
        en1    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_tgt(input int th, input int ca);
        tgt[0] = W'(th);
        for (int i = 1; i < 6; i++) tgt[i] = W'(4);
        tgt[6] = W'(ca);
    endtask

    initial begin
        int pcnt;
        int done_at;
        int exp_ca [5];

        // Main ramp: theta->2, l6->6, l5b/l5a->2, l4/l23->1, ca->12288
        tbl[0] = '{0,  '{4,4,4,4,4,4,8192},  '{4,4,4,4,4,4,8192},  0, 0};
        tbl[1] = '{3,  '{4,4,4,4,4,4,8192},  '{4,4,4,4,4,4,8192},  0, 0};
        tbl[2] = '{1,  '{2,6,2,2,1,1,12288}, '{4,4,4,4,4,4,8192},  1, 0};
        tbl[3] = '{15, '{2,6,2,2,1,1,12288}, '{4,4,4,4,4,4,8192},  1, 0};
        tbl[4] = '{1,  '{2,6,2,2,1,1,12288}, '{3,5,3,3,3,3,8704},  1, 0};
        tbl[5] = '{16, '{2,6,2,2,1,1,12288}, '{2,6,2,2,2,2,9216},  1, 0};
        tbl[6] = '{16, '{2,6,2,2,1,1,12288}, '{2,6,2,2,1,1,9728},  1, 0};
        tbl[7] = '{79, '{2,6,2,2,1,1,12288}, '{2,6,2,2,1,1,11776}, 1, 0};
        tbl[8] = '{1,  '{2,6,2,2,1,1,12288}, '{2,6,2,2,1,1,12288}, 0, 1};
        tbl[9] = '{1,  '{2,6,2,2,1,1,12288}, '{2,6,2,2,1,1,12288}, 0, 0};

        for (int i = 0; i < 7; i++) begin
            tgt[i]  = W'(4);
            tgt1[i] = W'(4);
        end
        tgt[6]  = W'(8192);
        tgt1[6] = W'(12288);

        do_reset();

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 7; i++) tgt[i] = W'(tbl[r].t[i]);
            cyc(tbl[r].n, 1'b1);
            for (int i = 0; i < 7; i++)
                chk($sformatf("vec%0d %s", r, cn[i]), q[i], tbl[r].e[i]);
            chk($sformatf("vec%0d ramping", r), int'(ramp), tbl[r].ramp);
            chk($sformatf("vec%0d settled_pulse", r), int'(pulse), tbl[r].pulse);
        end

        // Async reset mid-ramp, then the ramp restarts from reset values
        do_reset();
        set_tgt(6, 12288);
        cyc(65, 1'b1);
        chk("pre_rst ca", q[6], 10240);
        chk("pre_rst theta", q[0], 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst ca", q[6], 8192);
        chk("async_rst theta", q[0], 4);
        chk("async_rst ramping", int'(ramp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(16, 1'b1);
        chk("restart no_step ca", q[6], 8192);
        cyc(1, 1'b1);
        chk("restart step1 ca", q[6], 8704);
        chk("restart step1 theta", q[0], 5);
        cyc(48, 1'b1);
        chk("restart step4 ca", q[6], 10240);

        // Retarget downward at ca=10240; dwell counter keeps running
        tgt[6] = W'(6144);
        pcnt = 0;
        for (int i = 0; i < 128; i++) begin
            cyc(1, 1'b1);
            if (pulse) pcnt++;
            if (i == 15) chk("retarget step1 ca", q[6], 9728);
        end
        chk("retarget final ca", q[6], 6144);
        chk("retarget pulses", pcnt, 1);
        chk("retarget ramping", int'(ramp), 0);
        cyc(1, 1'b0);
        chk("pulse cleared en=0", int'(pulse), 0);

        // clk_en stalled 100 cycles mid-ramp
        do_reset();
        set_tgt(4, 12288);
        cyc(21, 1'b1);
        chk("stall pre ca", q[6], 8704);
        cyc(100, 1'b0);
        chk("stall hold ca", q[6], 8704);
        chk("stall hold ramping", int'(ramp), 1);
        cyc(11, 1'b1);
        chk("stall resume ca", q[6], 8704);
        cyc(1, 1'b1);
        chk("stall resume step ca", q[6], 9216);

        // Coarse instance: CA_STEP=1000, one tick per step
        exp_ca = '{9192, 10192, 11192, 12192, 12288};
        en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        chk("coarse entry ca", q1[6], 8192);
        chk("coarse entry ramping", int'(ramp1), 1);
        for (int k = 0; k < 5; k++) begin
            en1 = 1'b1;
            @(negedge clk);
            en1 = 1'b0;
            chk($sformatf("coarse step%0d ca", k + 1), q1[6], exp_ca[k]);
            chk($sformatf("coarse step%0d pulse", k + 1), int'(pulse1), (k == 4) ? 1 : 0);
        end
        chk("coarse ramping end", int'(ramp1), 0);

`ifdef MU_RAMP_HOLD_EN
        // Hold freezes the ramp for 40 ticks; completion slips by 40
        do_reset();
        set_tgt(4, 12288);
        cyc(21, 1'b1);
        hold = 1'b1;
        cyc(40, 1'b1);
        hold = 1'b0;
        chk("hold ca", q[6], 8704);
        chk("hold ramping", int'(ramp), 1);
        done_at = -1;
        for (int i = 0; i < 300 && done_at < 0; i++) begin
            cyc(1, 1'b1);
            if (pulse) done_at = i + 1;
        end
        chk("hold completion tick", done_at, 128 + 40 - 60);
        chk("hold final ca", q[6], 12288);
        set_tgt(4, 8192);
        hold = 1'b1;
        cyc(5, 1'b1);
        chk("hold blocks idle entry", int'(ramp), 0);
        hold = 1'b0;
        cyc(1, 1'b1);
        chk("hold release entry", int'(ramp), 1);
`else
        done_at = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
